// File: rtl/ram_copy_engine.sv
// Word-at-a-time block copier for the single-port synchronous 32-bit RAM.
// Optional running checksum of written words: define COPY_CHECKSUM_EN.
module ram_copy_engine #(
  parameter int unsigned DEPTH = 10000,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [32:0] DEPTH_LIM = 33'(DEPTH);

  state_t state_q, state_d;

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_inc;
  logic [LEN_W-1:0] words_q;
  logic [31:0]      buf_q;
  logic [31:0]      addr_q;
  logic [31:0]      addr_d;
  logic             err_q;

  logic [32:0]      src_end;
  logic [32:0]      dst_end;
  logic             range_bad;
  logic             len_zero;
  logic             accept;
  logic             last_word;

  // 33-bit end addresses so a region running past 2^32 cannot wrap back into range
  assign src_end   = {1'b0, src_addr} + 33'(len);
  assign dst_end   = {1'b0, dst_addr} + 33'(len);
  assign range_bad = (src_end > DEPTH_LIM) || (dst_end > DEPTH_LIM);
  assign len_zero  = (len == '0);
  assign accept    = (state_q == S_IDLE) && start;
  assign idx_inc   = idx_q + 1'b1;
  assign last_word = (idx_inc == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_zero || range_bad) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            addr_d  = src_addr;
          end
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        state_d = S_WRITE;
        addr_d  = dst_q + 32'(idx_q);
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          addr_d  = src_q + 32'(idx_inc);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (accept) begin
        src_q   <= src_addr;
        dst_q   <= dst_addr;
        len_q   <= len;
        idx_q   <= '0;
        words_q <= '0;
        err_q   <= !len_zero && range_bad;
      end
      if (state_q == S_LATCH) begin
        buf_q <= mem_rd;
      end
      if (state_q == S_WRITE) begin
        idx_q   <= idx_inc;
        words_q <= words_q + 1'b1;
      end
    end
  end

`ifdef COPY_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (state_q == S_WRITE) begin
      sum_q <= sum_q + buf_q;
    end
  end

  assign checksum = sum_q;
`endif

  // Strobes decode straight from the state register so reset kills mem_we at once
  assign mem_we     = (state_q == S_WRITE);
  assign busy       = (state_q == S_READ) || (state_q == S_LATCH) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign words_done = words_q;
  assign mem_addr   = addr_q;
  assign mem_wd     = buf_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural RAM and a write scoreboard.
module tb_ram_copy_engine;

  localparam int unsigned DEPTH = 10000;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned AW    = 14;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] words_done;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;
`ifdef COPY_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  ram_copy_engine #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
`ifdef COPY_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1];
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [31:0] pre_wd;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr[AW-1:0]] <= pre_wd;
    end else if (mem_we) begin
      if (mem_addr < DEPTH) mem[mem_addr[AW-1:0]] <= mem_wd;
    end else begin
      mem_rd <= mem[mem_addr[AW-1:0]];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  we_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      we_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wd, e.data);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_wd   = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // Issues one start and waits for done; inject>0 pulses a competing start mid-transfer.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l,
                     input logic exp_ok, input int inject,
                     output int lat, output logic bsy, output logic e1, output int wes);
    int          we0;
    logic [31:0] ix;
    we0 = we_cnt;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    if (exp_ok) begin
      for (int k = 0; k < int'(l); k++) begin
        ix = s + 32'(k);
        sb_q.push_back('{d + 32'(k), mem[ix[AW-1:0]]});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bsy = busy; e1 = err;
    while (!done && lat < 200) begin
      if (lat == inject) begin
        start = 1'b1; src_addr = 32'd50; dst_addr = 32'd0; len = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      bsy = bsy | busy;
    end
    start = 1'b0;
    wes = we_cnt - we0;
  endtask

  int   lat, wes;
  logic bsy, e1;

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    pre_we = 1'b0; pre_addr = '0; pre_wd = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wd", mem_wd, 32'd0);

    preload(32'd0, 32'h11); preload(32'd1, 32'h22);
    preload(32'd2, 32'h33); preload(32'd3, 32'h44);
    preload(32'd4, 32'h55);
    preload(32'd9996, 32'hA0); preload(32'd9997, 32'hA1);
    preload(32'd9998, 32'hA2); preload(32'd9999, 32'hA3);
    preload(32'd402, 32'hAAAA); preload(32'd403, 32'hBBBB);
    preload(32'd500, 32'hFFFF_FFFF); preload(32'd501, 32'h2);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word copy
    run(32'd0, 32'd100, 16'd4, 1'b1, 0, lat, bsy, e1, wes);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_latency", 32'(lat), 32'd13);
    chk("t1_words", 32'(words_done), 32'd4);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_we_cycles", 32'(wes), 32'd4);
    chk("t1_busy", 32'(bsy), 32'd1);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_ram100", mem[100], 32'h11);
    chk("t1_ram101", mem[101], 32'h22);
    chk("t1_ram102", mem[102], 32'h33);
    chk("t1_ram103", mem[103], 32'h44);

    // Zero length
    run(32'd0, 32'd0, 16'd0, 1'b0, 0, lat, bsy, e1, wes);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_latency", 32'(lat), 32'd1);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_we_cycles", 32'(wes), 32'd0);
    chk("t2_busy", 32'(bsy), 32'd0);
    chk("t2_words", 32'(words_done), 32'd0);

    // Source overruns DEPTH
    run(32'd9998, 32'd0, 16'd3, 1'b0, 0, lat, bsy, e1, wes);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_we_cycles", 32'(wes), 32'd0);
    chk("t3_busy", 32'(bsy), 32'd0);
    @(posedge clk); #1;
    chk("t3_err_held", 32'(err), 32'd1);

    // Destination overruns DEPTH
    run(32'd0, 32'd9999, 16'd2, 1'b0, 0, lat, bsy, e1, wes);
    chk("t3b_err", 32'(err), 32'd1);
    chk("t3b_we_cycles", 32'(wes), 32'd0);

    // Valid start clears err
    run(32'd1, 32'd300, 16'd1, 1'b1, 0, lat, bsy, e1, wes);
    chk("t4_err_cleared", 32'(e1), 32'd0);
    chk("t4_latency", 32'(lat), 32'd4);
    chk("t4_ram300", mem[300], 32'h22);

    // Regions ending exactly at DEPTH are legal
    run(32'd9996, 32'd9000, 16'd4, 1'b1, 0, lat, bsy, e1, wes);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_latency", 32'(lat), 32'd13);
    chk("t5_ram9003", mem[9003], 32'hA3);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Start while busy is ignored
    run(32'd0, 32'd200, 16'd5, 1'b1, 4, lat, bsy, e1, wes);
    chk("t6_latency", 32'(lat), 32'd16);
    chk("t6_words", 32'(words_done), 32'd5);
    chk("t6_we_cycles", 32'(wes), 32'd5);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("t6_no_restart", 32'(busy), 32'd0);

    // Reset during the write of word 2
    @(posedge clk); #1;
    src_addr = 32'd0; dst_addr = 32'd400; len = 16'd4; start = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back('{32'd400 + 32'(k), mem[k]});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t7_in_write", 32'(mem_we), 32'd1);
    chk("t7_words_pre", 32'(words_done), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t7_we_async", 32'(mem_we), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_words", 32'(words_done), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_sb_left", 32'(sb_q.size()), 32'd2);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_no_done", 32'(done), 32'd0);
    chk("t7_ram400", mem[400], 32'h11);
    chk("t7_ram401", mem[401], 32'h22);
    chk("t7_ram403", mem[403], 32'hBBBB);

    // Recovery after reset
    run(32'd4, 32'd700, 16'd1, 1'b1, 0, lat, bsy, e1, wes);
    chk("t8_latency", 32'(lat), 32'd4);
    chk("t8_ram700", mem[700], 32'h55);

`ifdef COPY_CHECKSUM_EN
    run(32'd500, 32'd600, 16'd2, 1'b1, 0, lat, bsy, e1, wes);
    chk("t9_checksum", checksum, 32'h1);
    @(posedge clk); #1;
    chk("t9_checksum_held", checksum, 32'h1);
`endif

    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Bus initiator for the team's single-port synchronous word RAM (DEPTH x 32).
- Reads a block of words from a source region and writes them to a destination region of the same RAM, one word at a time.
- A control FSM or CPU-side logic drives it through a start/busy/done handshake.
- Its memory-side ports connect directly to the RAM's we/address/wd/rd pins.

Parameters:
- DEPTH, 10000, number of 32-bit words in the attached RAM; valid addresses are 0..DEPTH-1.
- LEN_W, 16, width of the transfer-length field and the progress counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  first source word address; captured on accepted start.
- dst_addr  in  32  first destination word address; captured on accepted start.
- len  in  LEN_W  number of words to copy; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  one-cycle pulse at end of transfer, including error and zero-length cases.
- err  out  1  range-error flag; set together with done, cleared on the next accepted start.
- words_done  out  LEN_W  count of words written in the current or last transfer.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM word address.
- mem_wd  out  32  RAM write data.
- mem_rd  in  32  RAM read data; registered by the RAM and valid the cycle after a read address is presented with mem_we=0.

Behaviour:
Clock and reset:
- One clock domain (clk).
- Reset is asynchronous and active-low (rst_n).
- Reset values: busy=0, done=0, err=0, words_done=0, mem_we=0, mem_addr=0, mem_wd=0, FSM in IDLE, internal index and buffer = 0.

States:
- IDLE: mem_we=0.
  - start=1 captures src, dst, len; clears err and words_done.
  - len==0 goes to DONE without touching the RAM.
  - src+len>DEPTH or dst+len>DEPTH (33-bit compare, no wrap) sets err and goes to DONE without touching the RAM.
  - Otherwise goes to READ with index i=0.
- READ (1 cycle): mem_addr=src+i, mem_we=0. Next state LATCH.
- LATCH (1 cycle): mem_we=0, mem_addr holds. The buffer captures mem_rd at the end of the cycle. Next state WRITE.
- WRITE (1 cycle): mem_addr=dst+i, mem_wd=buffer, mem_we=1.
  - At the end of the cycle: words_done+=1, i+=1.
  - If i+1==len, next state DONE; otherwise READ.
- DONE (1 cycle): done=1, busy=0, mem_we=0. Next state IDLE.

Timing and handshake:
- Throughput is 3 cycles per word.
- Total latency from accepted start to the done pulse is 3*len+1 cycles (len>0, no error).
- Zero-length and error cases: done is asserted 1 cycle after start.
- mem_we is high only in WRITE. The RAM never sees a write outside [dst, dst+len).
- start while busy or in DONE is ignored and not queued.
- Overlapping regions are copied in ascending address order, with no overlap detection. If dst>src and the regions overlap, the result is the ascending-order copy; software must avoid this case.
- Address arithmetic is 32-bit. The range check guarantees no wrap.

Reset mid-transfer:
- mem_we drops immediately (asynchronously) and the FSM returns to IDLE.
- Words already written stay written; no done pulse is produced.

Optional Feature:
- Macro: COPY_CHECKSUM_EN.
- When defined:
  - Extra output checksum (32-bit) holds the mod-2^32 sum of every word written in the current transfer.
  - It is cleared on accepted start, updated in WRITE, held after done, and reset to 0 by rst_n.
- When undefined:
  - The port and adder are absent.
  - All other behaviour is identical.

Test Plan:
- Preload RAM[0..3]=0x11,0x22,0x33,0x44; start src=0 dst=100 len=4 -> RAM[100..103]=0x11..0x44; done pulses exactly 13 cycles after start; words_done=4; err=0; mem_we high exactly 4 cycles.
- start len=0 -> done the next cycle; err=0; mem_we never asserted; busy never high.
- start src=9998 dst=0 len=3 (DEPTH=10000) -> err=1 and done the next cycle; no RAM writes; err clears on the next valid start.
- During a len=5 transfer, pulse start with src=50 -> ignored; the original transfer completes with words_done=5.
- Assert rst_n=0 during WRITE of word 2 of a len=4 copy -> mem_we=0 asynchronously; busy=0; words_done=0; RAM[dst+2] either unchanged or written; RAM[dst+3] untouched.
- With COPY_CHECKSUM_EN: copy 0xFFFFFFFF,0x00000002 -> checksum=0x00000001 after done.
